// File: rtl/merge21_pkt_arbiter.sv
// 2:1 packet-merge arbiter: grants whole packets round-robin, holds the grant until the
// tail flit is accepted, and drives a single registered output stage with source tagging.
module merge21_pkt_arbiter #(
    parameter int W         = 9,
    parameter int MAX_FLITS = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [W-1:0] in0_data,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in1_data,
    input  logic         in1_valid,
    output logic         in1_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sel,
    output logic         err_len
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_FLITS);

    state_t       state, state_nx;
    logic         rr_ptr, rr_nx;
    logic [7:0]   flit_cnt, cnt_nx, cnt_inc;
    logic         err_q, err_nx;

    logic [W-1:0] data_p1;
    logic         sel_p1;
    logic         vld_p1;

    logic         load_ok;
    logic         grant;
    logic         acc0, acc1, acc;
    logic         acc_sel;
    logic [W-1:0] acc_data;
    logic         acc_tail;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign load_ok = !vld_p1 || out_ready;
    assign cnt_inc = sat_inc(flit_cnt);

    always_comb begin
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        grant     = rr_ptr;
        state_nx  = state;
        rr_nx     = rr_ptr;
        cnt_nx    = flit_cnt;
        err_nx    = err_q;

        // Readies: in IDLE only the granted requester may see ready; a lock pins it.
        case (state)
            IDLE: begin
                grant     = (in0_valid && in1_valid) ? rr_ptr : in1_valid;
                in0_ready = load_ok && in0_valid && !grant;
                in1_ready = load_ok && in1_valid && grant;
            end
            LOCK0:   in0_ready = load_ok;
            LOCK1:   in1_ready = load_ok;
            default: ;
        endcase

        acc0     = in0_valid && in0_ready;
        acc1     = in1_valid && in1_ready;
        acc      = acc0 || acc1;
        acc_sel  = acc1;
        acc_data = acc1 ? in1_data : in0_data;
        acc_tail = acc_data[W-1];

        case (state)
            IDLE: begin
                if (acc) begin
                    rr_nx  = ~acc_sel;
                    cnt_nx = 8'd1;
                    if (!acc_tail)
                        state_nx = acc_sel ? LOCK1 : LOCK0;
                end
            end
            LOCK0, LOCK1: begin
                if (acc) begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc > MAX_CNT)
                        err_nx = 1'b1;
                    if (acc_tail) begin
                        state_nx = IDLE;
                        cnt_nx   = 8'd0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            flit_cnt <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            rr_ptr   <= rr_nx;
            flit_cnt <= cnt_nx;
            err_q    <= err_nx;
        end
    end

    // Stage p1: single-entry output buffer, refilled in the same cycle it drains.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            sel_p1  <= 1'b0;
        end else if (acc) begin
            vld_p1  <= 1'b1;
            data_p1 <= acc_data;
            sel_p1  <= acc_sel;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_data  = data_p1;
    assign out_valid = vld_p1;
    assign out_sel   = sel_p1;
    assign err_len   = err_q;

endmodule

// File: tb/tb_merge21_pkt_arbiter.sv
// Bench for merge21_pkt_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a packet-ownership model.
module tb_merge21_pkt_arbiter;

    localparam int W    = 9;
    localparam int MAXF = 4;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [W-1:0] in0_data, in1_data, out_data;
    logic         in0_valid, in1_valid, in0_ready, in1_ready;
    logic         out_valid, out_ready, out_sel, err_len;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    merge21_pkt_arbiter #(.W(W), .MAX_FLITS(MAXF)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .in0_data (in0_data),
        .in0_valid(in0_valid),
        .in0_ready(in0_ready),
        .in1_data (in1_data),
        .in1_valid(in1_valid),
        .in1_ready(in1_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sel  (out_sel),
        .err_len  (err_len)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Model: who owns the output channel, whose turn it is, and what sits in the buffer.
    bit         m_ov    = 1'b0;
    logic [8:0] m_od    = '0;
    bit         m_os    = 1'b0;
    bit         m_err   = 1'b0;
    int         m_owner = -1;
    bit         m_rr    = 1'b0;
    int         m_cnt   = 0;
    bit         cmp_en  = 1'b0;
    int         m_a;
    logic [8:0] m_in;

    function automatic int m_pick();
        if (in0_valid && in1_valid) return int'(m_rr);
        if (in0_valid) return 0;
        if (in1_valid) return 1;
        return -1;
    endfunction

    function automatic bit m_ready(input int n);
        if (m_ov && !out_ready) return 1'b0;
        if (m_owner >= 0) return m_owner == n;
        return m_pick() == n;
    endfunction

    function automatic int m_acc();
        if (in0_valid && m_ready(0)) return 0;
        if (in1_valid && m_ready(1)) return 1;
        return -1;
    endfunction

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    always_comb begin
        m_a  = m_acc();
        m_in = (m_a == 1) ? in1_data : in0_data;
    end

    always @(posedge CLK) begin
        if (RESET) begin
            m_ov <= 1'b0; m_od <= '0; m_os <= 1'b0; m_err <= 1'b0;
            m_owner <= -1; m_rr <= 1'b0; m_cnt <= 0;
        end else if (m_a >= 0) begin
            m_ov <= 1'b1;
            m_od <= m_in;
            m_os <= (m_a == 1);
            if (m_owner < 0) begin
                m_rr    <= (m_a == 0);
                m_cnt   <= 1;
                m_owner <= m_in[8] ? -1 : m_a;
            end else begin
                if (sat255(m_cnt + 1) > MAXF) m_err <= 1'b1;
                m_cnt <= m_in[8] ? 0 : sat255(m_cnt + 1);
                if (m_in[8]) m_owner <= -1;
            end
        end else if (out_ready) begin
            m_ov <= 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("err_len",   32'(err_len),   32'(m_err));
            chk("in0_ready", 32'(in0_ready), 32'(m_ready(0)));
            chk("in1_ready", 32'(in1_ready), 32'(m_ready(1)));
            if (m_ov) begin
                chk("out_data", 32'(out_data), 32'(m_od));
                chk("out_sel",  32'(out_sel),  32'(m_os));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [8:0] d, input bit s);
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_data"},  32'(out_data),  32'(d));
        chk({nm, "_sel"},   32'(out_sel),   32'(s));
    endtask

    logic [8:0] s3 [3];
    logic [8:0] gd [2];
    int         grem [2];
    bit         ghave [2];
    bit         ga [2];
    bit         gv [2];

    initial begin
        RESET = 1'b1; out_ready = 1'b1;
        in0_valid = 1'b0; in1_valid = 1'b0; in0_data = '0; in1_data = '0;

        // Reset state
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_err",       32'(err_len),   32'd0);
        chk("rst_in0_ready", 32'(in0_ready), 32'd0);
        chk("rst_in1_ready", 32'(in1_ready), 32'd0);
        cmp_en = 1'b1;
        RESET  = 1'b0;

        // Single-flit contention alternates 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            in0_valid = 1'b1; in1_valid = 1'b1;
            in0_data = 9'h100 | 9'(i);
            in1_data = 9'h110 | 9'(i);
            tick();
            chk_out("t2", (i % 2 == 1) ? (9'h110 | 9'(i)) : (9'h100 | 9'(i)), (i % 2 == 1));
        end

        // Packet lock holds off requester 1
        s3[0] = 9'h001; s3[1] = 9'h002; s3[2] = 9'h103;
        for (int k = 0; k < 4; k++) begin
            in0_valid = (k < 3);
            if (k < 3) in0_data = s3[k];
            in1_valid = 1'b1; in1_data = 9'h1AA;
            #1;
            if (k < 3) chk("t3_in1_ready_lock", 32'(in1_ready), 32'd0);
            tick();
            chk_out("t3", (k < 3) ? s3[k] : 9'h1AA, (k == 3));
        end
        chk("t3_model_data", 32'(m_od), 32'h1AA);
        chk("t3_model_sel",  32'(m_os), 32'd1);

        // Backpressure mid-packet
        in1_valid = 1'b0; in0_valid = 1'b1; in0_data = 9'h011;
        tick(); chk_out("t4a", 9'h011, 1'b0);
        in0_data = 9'h012;
        tick(); chk_out("t4b", 9'h012, 1'b0);
        out_ready = 1'b0; in0_data = 9'h013; in1_valid = 1'b1; in1_data = 9'h1BB;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("t4_stall_in0_ready", 32'(in0_ready), 32'd0);
            chk("t4_stall_in1_ready", 32'(in1_ready), 32'd0);
            tick();
            chk_out("t4_hold", 9'h012, 1'b0);
        end
        out_ready = 1'b1;
        tick(); chk_out("t4c", 9'h013, 1'b0);
        in0_data = 9'h114;
        tick(); chk_out("t4d", 9'h114, 1'b0);
        in0_valid = 1'b0;
        tick(); chk_out("t4e", 9'h1BB, 1'b1);
        in1_valid = 1'b0;

        // Over-length packet on requester 1
        for (int k = 0; k < 6; k++) begin
            in1_valid = 1'b1;
            in1_data = (k == 5) ? 9'h126 : 9'(32'h21 + k);
            tick();
            chk_out("t5", (k == 5) ? 9'h126 : 9'(32'h21 + k), 1'b1);
            chk("t5_err", 32'(err_len), 32'(k >= 4));
        end
        in1_valid = 1'b0;
        tick(); chk("t5_err_hold", 32'(err_len), 32'd1);
        RESET = 1'b1;
        tick();
        chk("t5_err_clr", 32'(err_len),   32'd0);
        chk("t5_rst_ov",  32'(out_valid), 32'd0);
        RESET = 1'b0;

        // Reset in the middle of a requester 0 packet
        in0_valid = 1'b1; in0_data = 9'h031;
        tick(); chk_out("t6a", 9'h031, 1'b0);
        in0_data = 9'h032; RESET = 1'b1;
        tick(); chk("t6_rst_ov", 32'(out_valid), 32'd0);
        RESET = 1'b0; in0_valid = 1'b0; in1_valid = 1'b1; in1_data = 9'h1C1;
        #1;
        chk("t6_in1_ready", 32'(in1_ready), 32'd1);
        tick(); chk_out("t6b", 9'h1C1, 1'b1);
        in1_valid = 1'b0;

        // Random traffic, model compared every cycle
        for (int n = 0; n < 2; n++) begin
            ghave[n] = 1'b0; grem[n] = 0; gd[n] = '0;
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge CLK);
            ga[0] = in0_valid && in0_ready;
            ga[1] = in1_valid && in1_ready;
            tick();
            for (int n = 0; n < 2; n++) begin
                if (ga[n]) begin
                    grem[n]--;
                    if (grem[n] == 0) ghave[n] = 1'b0;
                    else gd[n] = {grem[n] == 1, 8'($urandom)};
                end
                if (!ghave[n] && $urandom_range(3) == 0) begin
                    grem[n]  = int'($urandom_range(7, 1));
                    ghave[n] = 1'b1;
                    gd[n]    = {grem[n] == 1, 8'($urandom)};
                end
                gv[n] = ghave[n] && ($urandom_range(7) != 0);
            end
            in0_valid = gv[0]; in0_data = gd[0];
            in1_valid = gv[1]; in1_data = gd[1];
            out_ready = ($urandom_range(3) != 0);
        end

        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
